pfiform_lane_serializer: RTL

- Downstream consumer of the PFIFORM reformatter on i_core_clk.
- Accepts one packed word of up to 16 lanes of 6 bits each from PFIFORM through the PopEnable/PopPermit handshake.
- Emits the valid lanes one per cycle, lane 0 first, on a valid/ready stream towards the per-lane processing stage.
- Marks the final lane of each word with o_lane_last.

---
 rtl/pfiform_lane_serializer_if.sv | 41 ++++
 rtl/pfiform_lane_serializer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pfiform_lane_serializer_if.sv
// PFIFORM word handshake plus the per-lane valid/ready stream, grouped for the lane serializer.
// master = PFIFORM/downstream side driving the serializer, slave = the serializer itself.
interface pfiform_lane_serializer_if #(
  parameter int LANE_W = 6,
  parameter int LANES  = 16,
  parameter int IDX_W  = 4
);
  logic                      PopEnable;
  logic                      PopPermit;
  logic [LANE_W*LANES-1:0]   PopData;
  logic [IDX_W-1:0]          LaneAmout;
  logic [LANE_W-1:0]         o_lane_data;
  logic                      o_lane_valid;
  logic                      o_lane_last;
  logic                      i_lane_ready;
  logic                      o_busy;

  modport master (
    output PopEnable,
    output PopData,
    output LaneAmout,
    output i_lane_ready,
    input  PopPermit,
    input  o_lane_data,
    input  o_lane_valid,
    input  o_lane_last,
    input  o_busy
  );

  modport slave (
    input  PopEnable,
    input  PopData,
    input  LaneAmout,
    input  i_lane_ready,
    output PopPermit,
    output o_lane_data,
    output o_lane_valid,
    output o_lane_last,
    output o_busy
  );
endinterface

// File: rtl/pfiform_lane_serializer.sv
// Takes packed PFIFORM words and streams their valid lanes one per cycle, lane 0 first.
// Optional macro PFIFORM_LANE_PREFETCH_EN adds a one-word prefetch buffer for bubble-free streaming.
module pfiform_lane_serializer #(
  parameter int LANE_W = 6,
  parameter int LANES  = 16,
  parameter int IDX_W  = 4
) (
  input  logic                        i_core_clk,
  input  logic                        i_rx_rstn,
  pfiform_lane_serializer_if.slave    bus
);
  localparam int WORD_W = LANE_W * LANES;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WORD_W-1:0]   r_hold;
  logic [WORD_W-1:0]   w_hold_next;
  logic [IDX_W-1:0]    r_amount;
  logic [IDX_W-1:0]    w_amount_next;
  logic [IDX_W-1:0]    r_index;
  logic [IDX_W-1:0]    w_index_next;

  logic [LANE_W-1:0]   w_lanes [LANES];
  logic                w_pop_permit;
  logic                w_xfer;
  logic                w_accept;
  logic                w_is_last;
  logic                w_lane_valid;

`ifdef PFIFORM_LANE_PREFETCH_EN
  logic [WORD_W-1:0]   r_pf_data;
  logic [WORD_W-1:0]   w_pf_data_next;
  logic [IDX_W-1:0]    r_pf_amount;
  logic [IDX_W-1:0]    w_pf_amount_next;
  logic                r_pf_full;
  logic                w_pf_full_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lanes[gi] = r_hold[gi*LANE_W +: LANE_W];
    end
  endgenerate

`ifdef PFIFORM_LANE_PREFETCH_EN
  assign w_pop_permit = ~r_pf_full;
`else
  assign w_pop_permit = (r_state == ST_IDLE);
`endif

  assign w_lane_valid = (r_state == ST_SHIFT);
  assign w_xfer       = bus.PopEnable & w_pop_permit;
  assign w_accept     = w_lane_valid & bus.i_lane_ready;
  assign w_is_last    = (r_index == r_amount);

  always_comb begin
    w_state_next  = r_state;
    w_hold_next   = r_hold;
    w_amount_next = r_amount;
    w_index_next  = r_index;
`ifdef PFIFORM_LANE_PREFETCH_EN
    w_pf_data_next   = r_pf_data;
    w_pf_amount_next = r_pf_amount;
    w_pf_full_next   = r_pf_full;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_hold_next   = bus.PopData;
          w_amount_next = bus.LaneAmout;
          w_index_next  = '0;
          w_state_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_accept && !w_is_last) begin
          w_index_next = r_index + IDX_W'(1);
        end else if (w_accept) begin
`ifdef PFIFORM_LANE_PREFETCH_EN
          // Prefetched word wins; otherwise a word arriving on this very edge goes straight in
          if (r_pf_full) begin
            w_hold_next    = r_pf_data;
            w_amount_next  = r_pf_amount;
            w_index_next   = '0;
            w_pf_full_next = 1'b0;
          end else if (w_xfer) begin
            w_hold_next   = bus.PopData;
            w_amount_next = bus.LaneAmout;
            w_index_next  = '0;
          end else begin
            w_index_next = '0;
            w_state_next = ST_IDLE;
          end
`else
          w_index_next = '0;
          w_state_next = ST_IDLE;
`endif
        end
`ifdef PFIFORM_LANE_PREFETCH_EN
        if (w_xfer && !(w_accept && w_is_last)) begin
          w_pf_data_next   = bus.PopData;
          w_pf_amount_next = bus.LaneAmout;
          w_pf_full_next   = 1'b1;
        end
`endif
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_amount <= '0;
      r_index  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_hold   <= w_hold_next;
      r_amount <= w_amount_next;
      r_index  <= w_index_next;
    end
  end

`ifdef PFIFORM_LANE_PREFETCH_EN
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_pf_data   <= '0;
      r_pf_amount <= '0;
      r_pf_full   <= 1'b0;
    end else begin
      r_pf_data   <= w_pf_data_next;
      r_pf_amount <= w_pf_amount_next;
      r_pf_full   <= w_pf_full_next;
    end
  end
`endif

  // Outputs decode straight from state so an async reset drops valid at once
  assign bus.PopPermit    = w_pop_permit;
  assign bus.o_lane_valid = w_lane_valid;
  assign bus.o_lane_data  = w_lane_valid ? w_lanes[r_index] : '0;
  assign bus.o_lane_last  = w_lane_valid & w_is_last;
  assign bus.o_busy       = w_lane_valid;

endmodule
